// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data memory request/ack bus between the MEM stage and data memory
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  ack
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output ack
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: load/store sequencing with timeout and MEM/WB register
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_regwrite,
  input  logic [3:0]        in_destreg,
  input  logic              in_memread,
  input  logic              in_memwrite,
  input  logic [15:0]       in_addr,
  input  logic [15:0]       in_result,
  output logic              stall,
  mem_stage_if.master       dmem,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic [3:0]        wb_destreg,
  output logic [15:0]       wb_data,
  output logic              bus_err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  // Last wait-counter value before the access is abandoned.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [3:0]  dest_q, dest_d;
  logic        rw_q, rw_d;
  logic        store_q, store_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic [3:0]  wb_destreg_q, wb_destreg_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic        bus_err_q, bus_err_d;

  // Next-state decode: accept in IDLE, complete or abort in REQ.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    dest_d        = dest_q;
    rw_d          = rw_q;
    store_d       = store_q;
    wb_valid_d    = 1'b0;
    wb_regwrite_d = 1'b0;
    wb_destreg_d  = wb_destreg_q;
    wb_data_d     = wb_data_q;
    bus_err_d     = bus_err_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (in_memread || in_memwrite) begin
            // A store wins when both type bits are set.
            state_d = S_REQ;
            cnt_d   = 8'd0;
            addr_d  = in_addr;
            wdata_d = in_result;
            dest_d  = in_destreg;
            rw_d    = in_regwrite;
            store_d = in_memwrite;
          end else begin
            wb_valid_d    = 1'b1;
            wb_regwrite_d = in_regwrite;
            wb_destreg_d  = in_destreg;
            wb_data_d     = in_result;
          end
        end
      end
      S_REQ: begin
        if (dmem.ack) begin
          // Ack beats the timeout on the same edge.
          state_d      = S_IDLE;
          wb_valid_d   = 1'b1;
          wb_destreg_d = dest_q;
          if (store_q) begin
            wb_data_d = wdata_q;
          end else begin
            wb_regwrite_d = rw_q;
            wb_data_d     = dmem.rdata;
          end
        end else if (cnt_q == WAIT_LAST) begin
          // Abandoned access: report it but never write the register file.
          state_d      = S_IDLE;
          wb_valid_d   = 1'b1;
          wb_destreg_d = dest_q;
          bus_err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and MEM/WB register update; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 8'd0;
      addr_q        <= 16'd0;
      wdata_q       <= 16'd0;
      dest_q        <= 4'd0;
      rw_q          <= 1'b0;
      store_q       <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_destreg_q  <= 4'd0;
      wb_data_q     <= 16'd0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      dest_q        <= dest_d;
      rw_q          <= rw_d;
      store_q       <= store_d;
      wb_valid_q    <= wb_valid_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_destreg_q  <= wb_destreg_d;
      wb_data_q     <= wb_data_d;
      bus_err_q     <= bus_err_d;
    end
  end

  // Bus and stall outputs decode directly from the request state.
  always_comb begin
    stall      = (state_q == S_REQ);
    dmem.req   = (state_q == S_REQ);
    dmem.we    = (state_q == S_REQ) && store_q;
    dmem.addr  = addr_q;
    dmem.wdata = wdata_q;
  end

  assign wb_valid    = wb_valid_q;
  assign wb_regwrite = wb_regwrite_q;
  assign wb_destreg  = wb_destreg_q;
  assign wb_data     = wb_data_q;
  assign bus_err     = bus_err_q;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum number of REQ cycles without dmem_ack before an access is aborted; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  the EX/MEM register holds a valid instruction.
REQ-005 in_regwrite  input  1  the instruction writes the register file.
REQ-006 in_destreg  input  4  destination register index.
REQ-007 in_memread  input  1  load instruction.
REQ-008 in_memwrite  input  1  store instruction.
REQ-009 in_addr  input  16  effective data address, base plus immediate.
REQ-010 in_result  input  16  ALU or immediate result; also the store data.
REQ-011 stall  output  1  the upstream EX/MEM register and earlier stages hold their contents.
REQ-012 dmem_req, dmem_we  output  1 each  data memory request and write enable.
REQ-013 dmem_addr, dmem_wdata  output  16 each  data memory address and write data.
REQ-014 dmem_rdata  input  16  read data, sampled only when dmem_ack=1.
REQ-015 dmem_ack  input  1  access complete.
REQ-016 wb_valid, wb_regwrite  output  1 each  MEM/WB register outputs.
REQ-017 wb_destreg  output  4  MEM/WB destination register index.
REQ-018 wb_data  output  16  data written back to the register file.
REQ-019 bus_err  output  1  sticky error flag, set when an access times out.

Function
REQ-020 The block SHALL implement a two-state FSM: IDLE and REQ.
REQ-021 stall SHALL be a combinational decode that equals 1 exactly when state=REQ.
REQ-022 In IDLE, a rising edge with in_valid=1 SHALL accept the instruction; in REQ, all in_* inputs SHALL be ignored.
REQ-023 Non-memory accept (in_memread=0 and in_memwrite=0): at the same edge, wb_valid SHALL become 1, wb_regwrite SHALL take in_regwrite, wb_destreg SHALL take in_destreg, and wb_data SHALL take in_result; this is one-cycle latency.
REQ-024 Memory accept: at the accepting edge, the block SHALL enter REQ and latch addr, store data, destreg, regwrite, and the type bit; dmem_we SHALL be 1 for a store.
REQ-025 If in_memread and in_memwrite are both 1, the block SHALL perform a store only.
REQ-026 In REQ, dmem_req SHALL be 1, and dmem_addr, dmem_wdata and dmem_we SHALL stay stable until the access terminates.
REQ-027 In IDLE, dmem_req and dmem_we SHALL be 0.
REQ-028 An edge in REQ with dmem_ack=1 SHALL return the FSM to IDLE and set wb_valid=1.
REQ-029 On a load completion, wb_data SHALL take dmem_rdata and wb_regwrite SHALL take the latched regwrite.
REQ-030 On a store completion, wb_regwrite SHALL be 0 and wb_data SHALL take the store data.
REQ-031 A wait counter SHALL clear on entry to REQ and increment on each REQ edge with dmem_ack=0.
REQ-032 An edge with counter=TIMEOUT-1 and dmem_ack=0 SHALL abort the access: return to IDLE, set wb_valid=1, set wb_regwrite=0, and set bus_err=1.
REQ-033 dmem_ack=1 on the timeout edge SHALL take priority over the timeout, so the access completes normally.
REQ-034 When no completion occurs at an edge, wb_valid and wb_regwrite SHALL be 0 at that edge; wb_destreg and wb_data SHALL hold their previous values.
REQ-035 dmem_ack while in IDLE SHALL be ignored.
REQ-036 Minimum memory latency SHALL be 2 edges (accept, then ack); there is no back-to-back overlap of accesses.

Reset
REQ-037 While reset=1 at an edge, the block SHALL set the state to IDLE, clear the counter, and set stall=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, wb_valid=0, wb_regwrite=0, wb_destreg=0, wb_data=0 and bus_err=0.
REQ-038 Reset SHALL take priority over every other event and SHALL abandon an access in progress without producing a writeback.
REQ-039 bus_err SHALL be cleared only by reset.

Verification
REQ-040 ALU pass-through: in_valid=1, regwrite=1, destreg=3, result=0x1234 -> next cycle wb_valid=1, wb_regwrite=1, wb_destreg=3, wb_data=0x1234, stall=0.
REQ-041 Load with ack after 3 REQ cycles, addr=0x00F0, rdata=0xBEEF, destreg=5 -> stall=1 for 3 cycles, addr stable; then wb_data=0xBEEF, wb_regwrite=1, wb_destreg=5.
REQ-042 Store addr=0x0010, result=0xCAFE, ack in the first REQ cycle -> dmem_we=1 and dmem_wdata=0xCAFE for 1 cycle; wb_valid=1, wb_regwrite=0.
REQ-043 Load, no ack, TIMEOUT=4 -> dmem_req high exactly 4 cycles; then wb_valid=1, wb_regwrite=0, bus_err=1, held high until reset.
REQ-044 Ack on the timeout edge (TIMEOUT=4, ack in the 4th cycle) -> normal load completion, bus_err remains 0.
REQ-045 Reset asserted during the 2nd REQ cycle -> next cycle stall=0, dmem_req=0, wb_valid=0; a new in_valid instruction is accepted normally.
